// File: rtl/formula_1_sched_pkg.sv
// Shared types and widths for the formula_1 issue scheduler and result collector.
package formula_1_sched_pkg;

  typedef enum logic [1:0] {IDLE, S_B, S_C} state_t;

  localparam int unsigned ARG_W  = 32;
  localparam int unsigned SQRT_W = 16;
  localparam int unsigned ACC_W  = 18;

endpackage

// File: rtl/formula_1_sched_collect.sv
// Sums every three in-order isqrt results into one formula result pulse.
module formula_1_sched_collect
  import formula_1_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sq_y_vld,
  input  logic [SQRT_W-1:0] sq_y,
  output logic              res_vld,
  output logic [ARG_W-1:0]  res
);

  logic [1:0]       cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  always_comb begin
    sum = acc + ACC_W'(sq_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      res_vld <= 1'b0;
      res     <= '0;
    end else begin
      res_vld <= 1'b0;
      if (sq_y_vld) begin
        case (cnt)
          2'd0: begin
            acc <= ACC_W'(sq_y);
            cnt <= 2'd1;
          end
          2'd1: begin
            acc <= sum;
            cnt <= 2'd2;
          end
          default: begin
            res     <= ARG_W'(sum);
            res_vld <= 1'b1;
            cnt     <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/formula_1_seq_sched.sv
// Issues a, b, c of each accepted triple to one shared pipelined isqrt and
// collects the three roots into res = isqrt(a) + isqrt(b) + isqrt(c).
module formula_1_seq_sched
  import formula_1_sched_pkg::*;
#(
  parameter int unsigned ISQRT_LAT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arg_vld,
  output logic              arg_rdy,
  input  logic [ARG_W-1:0]  a,
  input  logic [ARG_W-1:0]  b,
  input  logic [ARG_W-1:0]  c,
  output logic              sq_x_vld,
  output logic [ARG_W-1:0]  sq_x,
  input  logic              sq_y_vld,
  input  logic [SQRT_W-1:0] sq_y,
  output logic              res_vld,
  output logic [ARG_W-1:0]  res
);

  state_t           state, state_nx;
  logic             pend, pend_nx;
  logic             take;
  logic             issue_nx;
  logic [ARG_W-1:0] x_nx;
  logic [ARG_W-1:0] a_q, b_q, c_q;

  // A triple taken in S_C arrives while c still owns the issue slot, so its a
  // is parked in a_q and issued from S_B (pend set) before b: no bubble.
  always_comb begin
    arg_rdy  = (state != S_B);
    take     = arg_vld && arg_rdy;
    state_nx = state;
    pend_nx  = pend;
    issue_nx = 1'b0;
    x_nx     = sq_x;
    case (state)
      IDLE: begin
        if (arg_vld) begin
          issue_nx = 1'b1;
          x_nx     = a;
          pend_nx  = 1'b0;
          state_nx = S_B;
        end
      end
      S_B: begin
        issue_nx = 1'b1;
        if (pend) begin
          x_nx    = a_q;
          pend_nx = 1'b0;
        end else begin
          x_nx     = b_q;
          state_nx = S_C;
        end
      end
      S_C: begin
        issue_nx = 1'b1;
        x_nx     = c_q;
        if (arg_vld) begin
          pend_nx  = 1'b1;
          state_nx = S_B;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend     <= 1'b0;
      sq_x_vld <= 1'b0;
      sq_x     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
    end else begin
      state    <= state_nx;
      pend     <= pend_nx;
      sq_x_vld <= issue_nx;
      if (issue_nx) sq_x <= x_nx;
      if (take) begin
        a_q <= a;
        b_q <= b;
        c_q <= c;
      end
    end
  end

  formula_1_sched_collect u_collect (
    .clk      (clk),
    .rst_n    (rst_n),
    .sq_y_vld (sq_y_vld),
    .sq_y     (sq_y),
    .res_vld  (res_vld),
    .res      (res)
  );

`ifndef SYNTHESIS
  logic                 a_iss_q;
  logic [ISQRT_LAT+2:0] a_sh;
  logic [7:0]           outst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_iss_q <= 1'b0;
      a_sh    <= '0;
      outst   <= '0;
    end else begin
      a_iss_q <= (state == IDLE && arg_vld) || (state == S_B && pend);
      a_sh    <= {a_sh[ISQRT_LAT+1:0], a_iss_q};
      outst   <= outst + {7'd0, sq_x_vld} - {7'd0, sq_y_vld};
    end
  end

  a_no_extra_result: assert property (@(posedge clk) disable iff (!rst_n)
    sq_y_vld |-> (outst != 8'd0));
  a_res_timing: assert property (@(posedge clk) disable iff (!rst_n)
    res_vld == a_sh[ISQRT_LAT+2]);
`endif

endmodule

// File: tb/tb_formula_1_seq_sched.sv
// Directed bench for formula_1_seq_sched with a behavioural 16-cycle isqrt pipe.
module tb_formula_1_seq_sched;

  localparam int unsigned LAT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arg_vld;
  logic        arg_rdy;
  logic [31:0] a, b, c;
  logic        sq_x_vld;
  logic [31:0] sq_x;
  logic        sq_y_vld;
  logic [15:0] sq_y;
  logic        res_vld;
  logic [31:0] res;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;

  formula_1_seq_sched #(.ISQRT_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .a(a), .b(b), .c(c), .sq_x_vld(sq_x_vld), .sq_x(sq_x),
    .sq_y_vld(sq_y_vld), .sq_y(sq_y), .res_vld(res_vld), .res(res)
  );

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  // External isqrt stand-in, sharing the design's reset.
  logic [LAT-1:0] pv;
  logic [15:0]    pd [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], sq_x_vld};
      pd[0] <= isqrt(sq_x);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign sq_y_vld = pv[LAT-1];
  assign sq_y     = pd[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] x_q[$];
  logic [31:0] r_q[$];
  int unsigned rc_q[$];
  always @(negedge clk) begin
    if (rst_n && sq_x_vld) x_q.push_back(sq_x);
    if (rst_n && res_vld) begin
      r_q.push_back(res);
      rc_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic clear_q();
    x_q.delete();
    r_q.delete();
    rc_q.delete();
  endtask

  task automatic wait_results(input int unsigned n, input int unsigned budget);
    int unsigned k;
    k = 0;
    while (r_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("result_count", r_q.size(), n);
  endtask

  typedef struct {
    logic [31:0] va, vb, vc;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int unsigned k;
    logic [31:0] hx;
    logic        hv;
    int unsigned tog;
    logic [31:0] bb_args[9];
    logic [2:0]  rdy_pat;
    int unsigned idx;

    rst_n = 1'b0; arg_vld = 1'b0; a = '0; b = '0; c = '0;
    vecs.push_back('{32'd4, 32'd9, 32'd16, 32'd9});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0002_FFFD});
    vecs.push_back('{32'd0, 32'd1, 32'd4, 32'd3});
    vecs.push_back('{32'd25, 32'd36, 32'd49, 32'd18});
    vecs.push_back('{32'd100, 32'd100, 32'd100, 32'd30});
    vecs.push_back('{32'd2, 32'd3, 32'd8, 32'd4});
    vecs.push_back('{32'd15, 32'd16, 32'd17, 32'd11});
    vecs.push_back('{32'd65535, 32'd65536, 32'd4294836225, 32'd66046});

    repeat (3) @(negedge clk);
    chk("rst_sq_x_vld", {31'd0, sq_x_vld}, 32'd0);
    chk("rst_sq_x", sq_x, 32'd0);
    chk("rst_res_vld", {31'd0, res_vld}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_arg_rdy", {31'd0, arg_rdy}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single triples: issue order, latency 20 from handshake, result value.
    foreach (vecs[i]) begin
      @(negedge clk);
      chk("idle_rdy", {31'd0, arg_rdy}, 32'd1);
      a = vecs[i].va; b = vecs[i].vb; c = vecs[i].vc; arg_vld = 1'b1;
      @(negedge clk);
      arg_vld = 1'b0;
      chk("issue_a", sq_x, vecs[i].va);
      chk("issue_a_vld", {31'd0, sq_x_vld}, 32'd1);
      chk("sb_rdy", {31'd0, arg_rdy}, 32'd0);
      @(negedge clk);
      chk("issue_b", sq_x, vecs[i].vb);
      @(negedge clk);
      chk("issue_c", sq_x, vecs[i].vc);
      k = 3;
      while (!res_vld && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("latency", k, 32'd20);
      chk("res", res, vecs[i].exp_res);
      @(negedge clk);
      chk("res_pulse_1cyc", {31'd0, res_vld}, 32'd0);
      chk("res_hold", res, vecs[i].exp_res);
    end

    // Idle: last issue was c of the final vector; nothing should toggle.
    hx = sq_x; hv = sq_x_vld; tog = 0;
    repeat (50) begin
      @(negedge clk);
      if (sq_x !== hx || sq_x_vld !== hv) tog++;
    end
    chk("idle_toggles", tog, 32'd0);
    chk("idle_sq_x", hx, 32'd4294836225);
    chk("idle_sq_x_vld", {31'd0, hv}, 32'd0);

    // Back-to-back under continuous arg_vld.
    bb_args = '{32'd0, 32'd1, 32'd4, 32'd25, 32'd36, 32'd49, 32'd100, 32'd100, 32'd100};
    rdy_pat = 3'b0;
    idx = 0;
    clear_q();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (idx < 3) begin
        a = bb_args[idx*3]; b = bb_args[idx*3+1]; c = bb_args[idx*3+2]; arg_vld = 1'b1;
      end else begin
        arg_vld = 1'b0;
      end
      case (i)
        0, 2, 5: chk($sformatf("bb_rdy_%0d", i), {31'd0, arg_rdy}, 32'd1);
        default: chk($sformatf("bb_rdy_%0d", i), {31'd0, arg_rdy}, 32'd0);
      endcase
      if (arg_rdy && arg_vld) idx++;
    end
    @(negedge clk);
    arg_vld = 1'b0;
    wait_results(3, 60);
    chk("bb_issue_count", x_q.size(), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < x_q.size()) chk($sformatf("bb_issue_%0d", i), x_q[i], bb_args[i]);
    if (r_q.size() == 3) begin
      chk("bb_res0", r_q[0], 32'd3);
      chk("bb_res1", r_q[1], 32'd18);
      chk("bb_res2", r_q[2], 32'd30);
      chk("bb_gap01", rc_q[1] - rc_q[0], 32'd3);
      chk("bb_gap12", rc_q[2] - rc_q[1], 32'd3);
    end
    repeat (10) @(negedge clk);
    chk("bb_no_extra", r_q.size(), 32'd3);

    // Backpressure: new triple offered during S_B is taken only in S_C.
    clear_q();
    @(negedge clk);
    a = 32'd4; b = 32'd9; c = 32'd16; arg_vld = 1'b1;
    @(negedge clk);
    a = 32'd81; b = 32'd4; c = 32'd0;
    chk("bp_rdy_sb", {31'd0, arg_rdy}, 32'd0);
    @(negedge clk);
    chk("bp_rdy_sc", {31'd0, arg_rdy}, 32'd1);
    @(negedge clk);
    arg_vld = 1'b0;
    wait_results(2, 60);
    repeat (10) @(negedge clk);
    chk("bp_issue_count", x_q.size(), 32'd6);
    if (x_q.size() == 6) begin
      chk("bp_issue_3", x_q[3], 32'd81);
      chk("bp_issue_4", x_q[4], 32'd4);
      chk("bp_issue_5", x_q[5], 32'd0);
    end
    if (r_q.size() == 2) begin
      chk("bp_res0", r_q[0], 32'd9);
      chk("bp_res1", r_q[1], 32'd11);
    end

    // Reset after b has been issued discards the partial triple.
    @(negedge clk);
    a = 32'd4; b = 32'd9; c = 32'd16; arg_vld = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    @(negedge clk);
    chk("mid_b_issued", sq_x, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sq_x", sq_x, 32'd0);
    chk("mid_rst_sq_x_vld", {31'd0, sq_x_vld}, 32'd0);
    chk("mid_rst_res", res, 32'd0);
    chk("mid_rst_res_vld", {31'd0, res_vld}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    repeat (30) @(negedge clk);
    chk("mid_no_res", r_q.size(), 32'd0);
    a = 32'd1; b = 32'd1; c = 32'd1; arg_vld = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    wait_results(1, 40);
    if (r_q.size() == 1) chk("post_rst_res", r_q[0], 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
